// File: rtl/key_conditioner_if.sv
// Button/power inputs and stretched time-change requests between the
// button front end and the clock top.
interface key_conditioner_if;
  logic       power;
  logic [2:0] btn_add;
  logic [2:0] btn_sub;
  logic [2:0] add_time;
  logic [2:0] sub_time;

  modport master (output power, btn_add, btn_sub, input add_time, sub_time);
  modport slave  (input power, btn_add, btn_sub, output add_time, sub_time);
endinterface

// File: rtl/key_conditioner.sv
// Six button channels (add/sub x sec/min/hour): synchronize, debounce,
// press/auto-repeat FSM and pulse stretcher, with add/sub conflict lockout.
module key_channel #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_PERIOD   = 12500000,
  parameter int PULSE_CYCLES    = 67108864
) (
  input  logic clk_src,
  input  logic reset,
  input  logic power,
  input  logic btn,
  input  logic clash,
  output logic clean,
  output logic pulse
);
  localparam int DW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int TMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam int PW   = $clog2(PULSE_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, FIRST, HOLD, REPEAT} state_t;

  logic [1:0]    sync;
  logic [1:0]    vld_pipe;
  logic [DW-1:0] db_cnt;
  logic          armed;
  state_t        state, state_n;
  logic [TW-1:0] tmr, tmr_n;
  logic          evt, go_first, kill;
  logic [PW-1:0] str_cnt;

  assign kill  = !power || clash;
  assign pulse = power && (str_cnt != '0);

  always_ff @(posedge clk_src or posedge reset) begin
    if (reset) begin
      sync     <= '0;
      vld_pipe <= '0;
      db_cnt   <= '0;
      clean    <= 1'b0;
    end else begin
      sync     <= {sync[0], btn};
      vld_pipe <= {vld_pipe[0], 1'b1};
      if (sync[1] == clean)
        db_cnt <= '0;
      else if (db_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
        clean  <= sync[1];
        db_cnt <= '0;
      end else if (db_cnt != '1)
        db_cnt <= db_cnt + 1'b1;
    end
  end

  always_comb begin
    state_n  = state;
    tmr_n    = tmr;
    evt      = 1'b0;
    go_first = 1'b0;
    if (kill) begin
      state_n = IDLE;
      tmr_n   = '0;
    end else begin
      case (state)
        IDLE: begin
          tmr_n = '0;
          if (clean && armed) begin
            state_n  = FIRST;
            go_first = 1'b1;
          end
        end
        FIRST: begin
          if (!clean) state_n = IDLE;
          else begin
            evt     = 1'b1;
            state_n = HOLD;
            tmr_n   = '0;
          end
        end
        HOLD: begin
          if (!clean) state_n = IDLE;
          else if (tmr == TW'(REPEAT_DELAY - 1)) begin
            evt     = 1'b1;
            state_n = REPEAT;
            tmr_n   = '0;
          end else if (tmr != '1) tmr_n = tmr + 1'b1;
        end
        REPEAT: begin
          if (!clean) state_n = IDLE;
          else if (tmr == TW'(REPEAT_PERIOD - 1)) begin
            evt   = 1'b1;
            tmr_n = '0;
          end else if (tmr != '1) tmr_n = tmr + 1'b1;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // A press is only accepted once the button has been seen released since
  // reset, so a key held through reset stays silent; a power-off period
  // re-arms so a key held at power-up counts as a new press.
  always_ff @(posedge clk_src or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      tmr     <= '0;
      armed   <= 1'b0;
      str_cnt <= '0;
    end else begin
      state <= state_n;
      tmr   <= tmr_n;
      if (go_first)
        armed <= 1'b0;
      else if (!power || (vld_pipe[1] && !sync[1] && !clean))
        armed <= 1'b1;
      if (kill)
        str_cnt <= '0;
      else if (evt)
        str_cnt <= PW'(PULSE_CYCLES);
      else if (str_cnt != '0)
        str_cnt <= str_cnt - 1'b1;
    end
  end
endmodule

module key_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_PERIOD   = 12500000,
  parameter int PULSE_CYCLES    = 67108864
) (
  input logic              clk_src,
  input logic              reset,
  key_conditioner_if.slave kif
);
  logic [5:0] clean_all, pulse_all;
  logic [2:0] clean_add, clean_sub, conf, clash;

  assign clean_add = clean_all[2:0];
  assign clean_sub = clean_all[5:3];
  assign clash     = conf | (clean_add & clean_sub);

  // Lockout latches on both-high and only releases once both are low.
  always_ff @(posedge clk_src or posedge reset) begin
    if (reset) conf <= '0;
    else       conf <= (clean_add & clean_sub) | (conf & (clean_add | clean_sub));
  end

  key_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .REPEAT_DELAY   (REPEAT_DELAY),
    .REPEAT_PERIOD  (REPEAT_PERIOD),
    .PULSE_CYCLES   (PULSE_CYCLES)
  ) u_ch [5:0] (
    .clk_src(clk_src),
    .reset  (reset),
    .power  (kif.power),
    .btn    ({kif.btn_sub, kif.btn_add}),
    .clash  ({clash, clash}),
    .clean  (clean_all),
    .pulse  (pulse_all)
  );

  assign kif.add_time = pulse_all[2:0];
  assign kif.sub_time = pulse_all[5:3];
endmodule

// File: doc/key_conditioner.md
KEY_CONDITIONER -- requirements
Module: key_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1000000, stable-sample count required to accept a raw button level change.
REQ-002 Parameter REPEAT_DELAY, default 50000000, held-cycles after first accepted press before auto-repeat starts.
REQ-003 Parameter REPEAT_PERIOD, default 12500000, cycles between auto-repeat pulses.
REQ-004 Parameter PULSE_CYCLES, default 67108864, cycles each output pulse is held high; sized to span at least one period of the slow time-change clock.
REQ-005 clk_src  input  1  sole clock; all state updates on its rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 power  input  1  high = block active; low = all outputs forced 0 and all channels held in IDLE.
REQ-008 btn_add  input  3  raw, asynchronous, bouncy push buttons, active-high; bit0 sec, bit1 min, bit2 hour.
REQ-009 btn_sub  input  3  raw push buttons, same bit mapping as btn_add.
REQ-010 add_time  output  3  stretched increment request per field; drives the clock top's add_time.
REQ-011 sub_time  output  3  stretched decrement request per field; drives the clock top's sub_time.

Function
REQ-012 Six independent channels (3 add, 3 sub) SHALL be implemented, each with synchronizer, debouncer, FSM and pulse stretcher.
REQ-013 Each raw input SHALL pass through a 2-flop synchronizer before any other logic.
REQ-014 Debouncer SHALL update its clean level only after the synchronized input differs from it for exactly DEBOUNCE_CYCLES consecutive cycles; any sample equal to the clean level clears the counter.
REQ-015 Channel FSM states: IDLE, FIRST, HOLD, REPEAT.
REQ-016 IDLE -> FIRST when clean level rises; FIRST SHALL last one cycle and issue one request event, then go to HOLD.
REQ-017 HOLD SHALL count cycles; at count == REPEAT_DELAY-1 it SHALL issue one request event and go to REPEAT.
REQ-018 REPEAT SHALL issue one request event every REPEAT_PERIOD cycles while the clean level stays high.
REQ-019 From FIRST, HOLD or REPEAT, clean level low SHALL return the FSM to IDLE next cycle; no request event is issued on release.
REQ-020 A request event SHALL load the channel's stretch counter with PULSE_CYCLES; the output bit SHALL be high while the counter is nonzero (first high cycle is the cycle after the event).
REQ-021 A request event arriving while the stretch counter is nonzero SHALL reload it; the pulse extends rather than duplicating.
REQ-022 Conflict: if the add and sub clean levels for the same field are both high, both FSMs of that field SHALL be forced to IDLE and both stretch counters cleared, until both clean levels are low.
REQ-023 Different fields SHALL not interact; simultaneous presses on different fields produce independent requests.
REQ-024 Counters SHALL be sized by clog2 of their parameter and SHALL saturate, never wrap.
REQ-025 power falling SHALL clear FSMs and stretch counters within one cycle; synchronizers and debouncers keep running so that a button held at power-up is treated as a new press.

Reset
REQ-026 reset high SHALL asynchronously clear synchronizers, debounce counters and clean levels to 0, FSMs to IDLE, stretch counters to 0, add_time and sub_time to 3'b000.
REQ-027 Reset asserted mid-pulse or mid-repeat SHALL terminate the output immediately; after release no event occurs until a fresh debounced rising edge.

Verification (DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8, PULSE_CYCLES=3)
REQ-028 Clean press: btn_add[1] held high 10 cycles -> add_time[1] high for exactly 3 cycles, starting 2+4+1+1 cycles after assertion; all other bits stay 0.
REQ-029 Bounce: btn_sub[0] toggles every 2 cycles for 12 cycles, then is released -> sub_time stays 3'b000 throughout.
REQ-030 Auto-repeat: btn_add[2] held 60 cycles -> first pulse, second pulse 20 cycles after the first event, then one pulse every 8 cycles; none after release.
REQ-031 Conflict: btn_add[0] and btn_sub[0] both held -> add_time[0] and sub_time[0] remain 0, while btn_add[1] held concurrently still yields its pulse.
REQ-032 Reset or power drop during REPEAT: outputs return to 0 within one cycle (asynchronously for reset); button still held after recovery -> reset: no pulse; power: new FIRST pulse after debounce.
